// File: rtl/nn_exec_pkg.sv
// Shared widths and ALU op-code enums for the NN execute stage.
package nn_exec_pkg;

  localparam int unsigned BusWidth     = 32;
  localparam int unsigned RegWidth     = 6;
  localparam int unsigned AluFunctBits = 3;

  typedef enum logic [AluFunctBits-1:0] {
    Alu1Add   = 3'b000,
    Alu1Sub   = 3'b001,
    Alu1Mul   = 3'b010,
    Alu1And   = 3'b011,
    Alu1Or    = 3'b100,
    Alu1Xor   = 3'b101,
    Alu1Slt   = 3'b110,
    Alu1PassB = 3'b111
  } alu1_op_e;

  typedef enum logic [AluFunctBits-1:0] {
    Alu2PassR1 = 3'b000,
    Alu2Add    = 3'b001,
    Alu2Sub    = 3'b010,
    Alu2Mul    = 3'b011,
    Alu2Relu   = 3'b100,
    Alu2Max    = 3'b101,
    Alu2Min    = 3'b110,
    Alu2Step   = 3'b111
  } alu2_op_e;

endpackage

// File: rtl/nn_execute_stage_if.sv
// Decode-to-execute bundle: decode-stage inputs and registered execute results.
interface nn_execute_stage_if;
  import nn_exec_pkg::*;

  logic                    pc_en_d;
  logic                    reg_write_d;
  logic                    alu1_src_d;
  logic                    reg_dst_d;
  logic                    mem_write_d;
  logic                    mem_to_reg_d;
  logic [AluFunctBits-1:0] alu1_cntrl_d;
  logic [AluFunctBits-1:0] alu2_cntrl_d;
  logic [BusWidth-1:0]     src1a_d;
  logic [BusWidth-1:0]     src1b_d;
  logic [BusWidth-1:0]     src1c_d;
  logic [RegWidth-1:0]     rt_d;
  logic [RegWidth-1:0]     rd_d;
  logic [BusWidth-1:0]     imm_d;

  logic                    pc_en;
  logic                    reg_write;
  logic                    mem_write;
  logic                    mem_to_reg;
  logic [RegWidth-1:0]     write_dst_reg;
  logic [BusWidth-1:0]     write_data;
  logic [BusWidth-1:0]     alu_out1;
  logic [BusWidth-1:0]     alu_out2;

  modport master (
    output pc_en_d, reg_write_d, alu1_src_d, reg_dst_d, mem_write_d, mem_to_reg_d,
           alu1_cntrl_d, alu2_cntrl_d, src1a_d, src1b_d, src1c_d, rt_d, rd_d, imm_d,
    input  pc_en, reg_write, mem_write, mem_to_reg, write_dst_reg, write_data,
           alu_out1, alu_out2
  );

  modport slave (
    input  pc_en_d, reg_write_d, alu1_src_d, reg_dst_d, mem_write_d, mem_to_reg_d,
           alu1_cntrl_d, alu2_cntrl_d, src1a_d, src1b_d, src1c_d, rt_d, rd_d, imm_d,
    output pc_en, reg_write, mem_write, mem_to_reg, write_dst_reg, write_data,
           alu_out1, alu_out2
  );

endinterface

// File: rtl/nn_alu_core.sv
// Combinational child ALU: R2 = g(R1, C).
// NNEX_SATURATE_EN makes add/sub/mul saturate on signed overflow instead of wrapping.
module nn_alu_core
  import nn_exec_pkg::*;
(
  input  alu2_op_e            i_op,
  input  logic [BusWidth-1:0] i_a,
  input  logic [BusWidth-1:0] i_b,
  output logic [BusWidth-1:0] o_y
);

  localparam logic [BusWidth-1:0] MaxPos = {1'b0, {(BusWidth-1){1'b1}}};
  localparam logic [BusWidth-1:0] MinNeg = {1'b1, {(BusWidth-1){1'b0}}};

  logic [BusWidth-1:0] w_sum, w_diff, w_add, w_sub, w_mul;
  logic                w_a_gt_b, w_a_ge_b;

  assign w_sum    = i_a + i_b;
  assign w_diff   = i_a - i_b;
  assign w_a_gt_b = $signed(i_a) > $signed(i_b);
  assign w_a_ge_b = $signed(i_a) >= $signed(i_b);

`ifdef NNEX_SATURATE_EN
  logic signed [2*BusWidth-1:0] w_prod;
  logic                         w_add_ovf, w_sub_ovf, w_mul_ovf;

  assign w_prod    = $signed(i_a) * $signed(i_b);
  assign w_add_ovf = (i_a[BusWidth-1] == i_b[BusWidth-1]) && (w_sum[BusWidth-1] != i_a[BusWidth-1]);
  assign w_sub_ovf = (i_a[BusWidth-1] != i_b[BusWidth-1]) && (w_diff[BusWidth-1] != i_a[BusWidth-1]);
  // Product fits only if the upper half is a sign-extension of bit BusWidth-1.
  assign w_mul_ovf = w_prod[2*BusWidth-1:BusWidth-1] != {(BusWidth+1){w_prod[BusWidth-1]}};
  assign w_add = w_add_ovf ? (i_a[BusWidth-1] ? MinNeg : MaxPos) : w_sum;
  assign w_sub = w_sub_ovf ? (i_a[BusWidth-1] ? MinNeg : MaxPos) : w_diff;
  assign w_mul = w_mul_ovf ? (w_prod[2*BusWidth-1] ? MinNeg : MaxPos) : w_prod[BusWidth-1:0];
`else
  assign w_add = w_sum;
  assign w_sub = w_diff;
  assign w_mul = i_a * i_b;
`endif

  always_comb begin
    o_y = i_a;
    case (i_op)
      Alu2PassR1: o_y = i_a;
      Alu2Add:    o_y = w_add;
      Alu2Sub:    o_y = w_sub;
      Alu2Mul:    o_y = w_mul;
      Alu2Relu:   o_y = i_a[BusWidth-1] ? '0 : i_a;
      Alu2Max:    o_y = w_a_gt_b ? i_a : i_b;
      Alu2Min:    o_y = w_a_gt_b ? i_b : i_a;
      Alu2Step:   o_y = {{(BusWidth-1){1'b0}}, w_a_ge_b};
      default:    o_y = i_a;
    endcase
  end

endmodule

// File: rtl/nn_execute_stage.sv
// ID/EX pipeline register, ALU1 source mux, destination mux and chained parent/child ALUs.
// Optional child-ALU saturation is enabled by defining NNEX_SATURATE_EN.
module nn_execute_stage
  import nn_exec_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  nn_execute_stage_if.slave  bus
);

  logic                r_pc_en, r_reg_write, r_alu1_src, r_reg_dst, r_mem_write, r_mem_to_reg;
  alu1_op_e            r_alu1_op;
  alu2_op_e            r_alu2_op;
  logic [BusWidth-1:0] r_src_a, r_src_b, r_src_c, r_imm;
  logic [RegWidth-1:0] r_rt, r_rd;

  // PCEn comes out of reset high so fetch keeps running.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc_en      <= 1'b1;
      r_reg_write  <= 1'b0;
      r_alu1_src   <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu1_op    <= Alu1Add;
      r_alu2_op    <= Alu2PassR1;
      r_src_a      <= '0;
      r_src_b      <= '0;
      r_src_c      <= '0;
      r_imm        <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
    end else begin
      r_pc_en      <= bus.pc_en_d;
      r_reg_write  <= bus.reg_write_d;
      r_alu1_src   <= bus.alu1_src_d;
      r_reg_dst    <= bus.reg_dst_d;
      r_mem_write  <= bus.mem_write_d;
      r_mem_to_reg <= bus.mem_to_reg_d;
      r_alu1_op    <= alu1_op_e'(bus.alu1_cntrl_d);
      r_alu2_op    <= alu2_op_e'(bus.alu2_cntrl_d);
      r_src_a      <= bus.src1a_d;
      r_src_b      <= bus.src1b_d;
      r_src_c      <= bus.src1c_d;
      r_imm        <= bus.imm_d;
      r_rt         <= bus.rt_d;
      r_rd         <= bus.rd_d;
    end
  end

  logic [BusWidth-1:0] w_opb, w_r1, w_r2;

  assign w_opb = r_alu1_src ? r_imm : r_src_b;

  // Parent ALU always wraps, independent of the saturation option.
  always_comb begin
    w_r1 = '0;
    case (r_alu1_op)
      Alu1Add:   w_r1 = r_src_a + w_opb;
      Alu1Sub:   w_r1 = r_src_a - w_opb;
      Alu1Mul:   w_r1 = r_src_a * w_opb;
      Alu1And:   w_r1 = r_src_a & w_opb;
      Alu1Or:    w_r1 = r_src_a | w_opb;
      Alu1Xor:   w_r1 = r_src_a ^ w_opb;
      Alu1Slt:   w_r1 = {{(BusWidth-1){1'b0}}, ($signed(r_src_a) < $signed(w_opb))};
      Alu1PassB: w_r1 = w_opb;
      default:   w_r1 = '0;
    endcase
  end

  nn_alu_core u_child_alu (
    .i_op (r_alu2_op),
    .i_a  (w_r1),
    .i_b  (r_src_c),
    .o_y  (w_r2)
  );

  assign bus.pc_en         = r_pc_en;
  assign bus.reg_write     = r_reg_write;
  assign bus.mem_write     = r_mem_write;
  assign bus.mem_to_reg    = r_mem_to_reg;
  assign bus.write_dst_reg = r_reg_dst ? r_rd : r_rt;
  assign bus.write_data    = r_src_b;
  assign bus.alu_out1      = w_r1;
  assign bus.alu_out2      = w_r2;

endmodule

// File: tb/tb_nn_execute_stage.sv
// Scoreboard bench for nn_execute_stage: directed vectors push expectations, a monitor checks.
module tb_nn_execute_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nn_execute_stage_if bus ();

  nn_execute_stage u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  ctl;  // {pc_en, reg_write, mem_write, mem_to_reg}
    logic [5:0]  dst;
    logic [31:0] wd;
    logic [31:0] o1;
    logic [31:0] o2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef NNEX_SATURATE_EN
  localparam logic [31:0] OvfAdd = 32'h7FFF_FFFF;
  localparam logic [31:0] OvfSub = 32'h8000_0000;
  localparam logic [31:0] OvfMul = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OvfAdd = 32'h8000_0000;
  localparam logic [31:0] OvfSub = 32'h7FFF_FFFF;
  localparam logic [31:0] OvfMul = 32'h0000_0000;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ctl = {pc_en, reg_write, alu1_src, reg_dst, mem_write, mem_to_reg}
  task automatic step(input logic rst_v, input logic [5:0] ctl, input logic [2:0] f1,
                      input logic [2:0] f2, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] imm, input logic [5:0] rt,
                      input logic [5:0] rd, input logic [3:0] ectl, input logic [5:0] edst,
                      input logic [31:0] ewd, input logic [31:0] eo1, input logic [31:0] eo2);
    exp_t e;
    @(negedge clk);
    rst              = rst_v;
    bus.pc_en_d      = ctl[5];
    bus.reg_write_d  = ctl[4];
    bus.alu1_src_d   = ctl[3];
    bus.reg_dst_d    = ctl[2];
    bus.mem_write_d  = ctl[1];
    bus.mem_to_reg_d = ctl[0];
    bus.alu1_cntrl_d = f1;
    bus.alu2_cntrl_d = f2;
    bus.src1a_d      = a;
    bus.src1b_d      = b;
    bus.src1c_d      = c;
    bus.imm_d        = imm;
    bus.rt_d         = rt;
    bus.rd_d         = rd;
    e.ctl = ectl;
    e.dst = edst;
    e.wd  = ewd;
    e.o1  = eo1;
    e.o2  = eo2;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_en",      {31'b0, bus.pc_en},      {31'b0, e.ctl[3]});
        chk("reg_write",  {31'b0, bus.reg_write},  {31'b0, e.ctl[2]});
        chk("mem_write",  {31'b0, bus.mem_write},  {31'b0, e.ctl[1]});
        chk("mem_to_reg", {31'b0, bus.mem_to_reg}, {31'b0, e.ctl[0]});
        chk("write_dst",  {26'b0, bus.write_dst_reg}, {26'b0, e.dst});
        chk("write_data", bus.write_data, e.wd);
        chk("alu_out1",   bus.alu_out1,   e.o1);
        chk("alu_out2",   bus.alu_out2,   e.o2);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bus.pc_en_d = 0; bus.reg_write_d = 0; bus.alu1_src_d = 0; bus.reg_dst_d = 0;
    bus.mem_write_d = 0; bus.mem_to_reg_d = 0; bus.alu1_cntrl_d = 0; bus.alu2_cntrl_d = 0;
    bus.src1a_d = 0; bus.src1b_d = 0; bus.src1c_d = 0; bus.imm_d = 0;
    bus.rt_d = 0; bus.rd_d = 0;

    // Reset with non-zero inputs: everything clears except PCEn.
    step(1, 6'b011111, 3'd2, 3'd1, 32'd5, 32'd6, 32'd7, 32'd9, 6'd3, 6'd4,
         4'b1000, 6'd0, 32'd0, 32'd0, 32'd0);
    // MAC 3*4+10
    step(0, 6'b110100, 3'd2, 3'd1, 32'd3, 32'd4, 32'd10, 32'd0, 6'd1, 6'd2,
         4'b1100, 6'd2, 32'd4, 32'd12, 32'd22);
    // Immediate, RegDst=0 then 1
    step(0, 6'b011010, 3'd0, 3'd0, 32'h20, 32'd7, 32'd0, 32'hFFFF_FFF0, 6'd5, 6'd9,
         4'b0110, 6'd5, 32'd7, 32'h10, 32'h10);
    step(0, 6'b011101, 3'd0, 3'd0, 32'h20, 32'd7, 32'd0, 32'hFFFF_FFF0, 6'd5, 6'd9,
         4'b0101, 6'd9, 32'd7, 32'h10, 32'h10);
    // ReLU of -5, then step(-5 >= -5)
    step(0, 6'b100000, 3'd1, 3'd4, 32'd1, 32'd6, 32'd0, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'd6, 32'hFFFF_FFFB, 32'd0);
    step(0, 6'b100000, 3'd1, 3'd7, 32'd1, 32'd6, 32'hFFFF_FFFB, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'd6, 32'hFFFF_FFFB, 32'd1);
    // Child add overflow
    step(0, 6'b100000, 3'd0, 3'd1, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'd0, 32'h7FFF_FFFF, OvfAdd);
    // Mid-stream reset
    step(1, 6'b011111, 3'd3, 3'd5, 32'd1, 32'd2, 32'd3, 32'd4, 6'd7, 6'd8,
         4'b1000, 6'd0, 32'd0, 32'd0, 32'd0);
    // AND then subtract
    step(0, 6'b110100, 3'd3, 3'd2, 32'hF0F0_F0F0, 32'h0FF0_FF00, 32'h0000_F000, 32'd0,
         6'd11, 6'd12, 4'b1100, 6'd12, 32'h0FF0_FF00, 32'h00F0_F000, 32'h00F0_0000);
    // OR then signed max against a negative R1
    step(0, 6'b100000, 3'd4, 3'd5, 32'd1, 32'h8000_0000, 32'd5, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'h8000_0000, 32'h8000_0001, 32'd5);
    // XOR then signed min with -1
    step(0, 6'b100010, 3'd5, 3'd6, 32'hFF, 32'h0F, 32'hFFFF_FFFF, 32'd0, 6'd20, 6'd0,
         4'b1010, 6'd20, 32'h0F, 32'hF0, 32'hFFFF_FFFF);
    // Signed SLT (-2 < 1) then multiply by 7
    step(0, 6'b100000, 3'd6, 3'd3, 32'hFFFF_FFFE, 32'd1, 32'd7, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'd1, 32'd1, 32'd7);
    // Pass immediate through both ALUs
    step(0, 6'b101000, 3'd7, 3'd0, 32'h55, 32'hAAAA, 32'd0, 32'h1234_5678, 6'd33, 6'd0,
         4'b1000, 6'd33, 32'hAAAA, 32'h1234_5678, 32'h1234_5678);
    // SLT is signed: 1 < -1 is false; step(0 >= 0)=1
    step(0, 6'b100000, 3'd6, 3'd7, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    // Max / min with positive operands
    step(0, 6'b100000, 3'd0, 3'd5, 32'd10, 32'd20, 32'd40, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'd20, 32'd30, 32'd40);
    step(0, 6'b100000, 3'd0, 3'd6, 32'd10, 32'd20, 32'd40, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'd20, 32'd30, 32'd30);
    // Parent multiply wraps to 0
    step(0, 6'b100000, 3'd2, 3'd1, 32'h1_0000, 32'h1_0000, 32'd3, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'h1_0000, 32'd0, 32'd3);
    // Child subtract / multiply overflow
    step(0, 6'b100000, 3'd0, 3'd2, 32'h8000_0000, 32'd0, 32'd1, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'd0, 32'h8000_0000, OvfSub);
    step(0, 6'b100000, 3'd0, 3'd3, 32'h4000_0000, 32'd0, 32'd4, 32'd0, 6'd0, 6'd0,
         4'b1000, 6'd0, 32'd0, 32'h4000_0000, OvfMul);
    // Largest register specifier via Rd
    step(0, 6'b110100, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 6'd0, 6'd63,
         4'b1100, 6'd63, 32'd0, 32'd0, 32'd0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
